player_motion: RTL and testbench

- Player-side counterpart to the enemy block, running on the same 1-tick game clock.
- Drives the player position that the enemy and collision logic consume. Handles horizontal movement from buttons and a jump FSM (rise / apex hold / fall).
- Performs its own bounding-box hit test against the enemy position, and owns lives, invulnerability and game-over.
- Outputs feed the VGA sprite renderer and the top-level game-state logic.

---
 rtl/player_motion.sv | 143 ++++++++++++++
 tb/tb_player_motion.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// Player position, jump FSM, enemy hit test, lives and game-over on the 1-tick game clock.
// Buttons and overlap take effect on the next clk_1s edge; there is no backpressure.
module player_motion #(
    parameter int X_START      = 100,
    parameter int Y_GROUND     = 440,
    parameter int X_MIN        = 50,
    parameter int X_MAX        = 590,
    parameter int JUMP_HEIGHT  = 120,
    parameter int RISE_STEP    = 2,
    parameter int FALL_STEP    = 2,
    parameter int APEX_HOLD    = 20,
    parameter int SIZE         = 50,
    parameter int LIVES_INIT   = 3,
    parameter int INVULN_TICKS = 200
) (
    input  logic        clk_1s,
    input  logic        reset,
    input  logic        jump_btn,
    input  logic        left_btn,
    input  logic        right_btn,
    input  logic [15:0] x_enemy,
    input  logic [15:0] y_enemy,
    output logic [15:0] x_player,
    output logic [15:0] y_player,
    output logic        jumping,
    output logic        hit,
    output logic [1:0]  lives,
    output logic        game_over
);
    localparam int AW = (APEX_HOLD > 1) ? $clog2(APEX_HOLD) : 1;
    localparam int IW = $clog2(INVULN_TICKS + 1);

    localparam logic [15:0] L_X_START    = 16'(X_START);
    localparam logic [15:0] L_Y_GROUND   = 16'(Y_GROUND);
    localparam logic [15:0] L_X_MIN      = 16'(X_MIN);
    localparam logic [15:0] L_X_MAX      = 16'(X_MAX);
    localparam logic [15:0] L_APEX_Y     = 16'(Y_GROUND - JUMP_HEIGHT);
    localparam logic [15:0] L_RISE_STEP  = 16'(RISE_STEP);
    localparam logic [15:0] L_FALL_STEP  = 16'(FALL_STEP);
    localparam logic [16:0] L_RISE_LIMIT = 17'(Y_GROUND - JUMP_HEIGHT + RISE_STEP);
    localparam logic [16:0] L_GROUND17   = 17'(Y_GROUND);
    localparam logic [16:0] L_FALL17     = 17'(FALL_STEP);
    localparam logic [16:0] L_SIZE       = 17'(SIZE);
    localparam logic [AW-1:0] L_APEX_LD  = AW'(APEX_HOLD - 1);
    localparam logic [IW-1:0] L_INVULN   = IW'(INVULN_TICKS);
    localparam logic [1:0]  L_LIVES_INIT = 2'(LIVES_INIT);

    typedef enum logic [2:0] {S_GROUND, S_RISE, S_APEX, S_FALL, S_DEAD} state_t;

    state_t          r_state;
    logic [15:0]     r_x;
    logic [15:0]     r_y;
    logic [AW-1:0]   r_apex_cnt;
    logic [IW-1:0]   r_invuln;
    logic [1:0]      r_lives;
    logic            r_hit;
    logic            r_jump_prev;

    logic            w_jump_edge;
    logic [16:0]     w_dx;
    logic [16:0]     w_dy;
    logic            w_overlap;
    logic            w_hit;
    logic [15:0]     w_x_next;

    assign w_jump_edge = jump_btn & ~r_jump_prev;

    // Distances in 17 bits so the subtraction never wraps.
    assign w_dx = (r_x >= x_enemy) ? ({1'b0, r_x} - {1'b0, x_enemy}) : ({1'b0, x_enemy} - {1'b0, r_x});
    assign w_dy = (r_y >= y_enemy) ? ({1'b0, r_y} - {1'b0, y_enemy}) : ({1'b0, y_enemy} - {1'b0, r_y});
    assign w_overlap = (w_dx < L_SIZE) & (w_dy < L_SIZE);
    assign w_hit     = w_overlap & (r_invuln == '0) & (r_state != S_DEAD);

    always_comb begin
        w_x_next = r_x;
        if (left_btn & ~right_btn & (r_x > L_X_MIN))
            w_x_next = r_x - 16'd1;
        else if (right_btn & ~left_btn & (r_x < L_X_MAX))
            w_x_next = r_x + 16'd1;
    end

    always_ff @(posedge clk_1s) begin
        if (reset) begin
            r_state     <= S_GROUND;
            r_x         <= L_X_START;
            r_y         <= L_Y_GROUND;
            r_apex_cnt  <= '0;
            r_invuln    <= '0;
            r_lives     <= L_LIVES_INIT;
            r_hit       <= 1'b0;
            r_jump_prev <= 1'b0;
        end else begin
            r_jump_prev <= jump_btn;
            if (r_state != S_DEAD) begin
                r_x <= w_x_next;
                case (r_state)
                    S_GROUND: if (w_jump_edge) r_state <= S_RISE;
                    S_RISE: begin
                        if ({1'b0, r_y} <= L_RISE_LIMIT) begin
                            r_y        <= L_APEX_Y;
                            r_apex_cnt <= L_APEX_LD;
                            r_state    <= S_APEX;
                        end else begin
                            r_y <= r_y - L_RISE_STEP;
                        end
                    end
                    S_APEX: begin
                        if (r_apex_cnt == '0) r_state <= S_FALL;
                        else                  r_apex_cnt <= r_apex_cnt - AW'(1);
                    end
                    S_FALL: begin
                        if (({1'b0, r_y} + L_FALL17) >= L_GROUND17) begin
                            r_y     <= L_Y_GROUND;
                            r_state <= S_GROUND;
                        end else begin
                            r_y <= r_y + L_FALL_STEP;
                        end
                    end
                    default: r_state <= S_DEAD;
                endcase
                r_hit <= w_hit;
                // The fatal hit overrides whatever jump transition was chosen above.
                if (w_hit) begin
                    r_lives  <= r_lives - 2'd1;
                    r_invuln <= L_INVULN;
                    if (r_lives == 2'd1) r_state <= S_DEAD;
                end else if (r_invuln != '0) begin
                    r_invuln <= r_invuln - IW'(1);
                end
            end else begin
                r_hit <= 1'b0;
            end
        end
    end

    assign x_player  = r_x;
    assign y_player  = r_y;
    assign jumping   = (r_state == S_RISE) | (r_state == S_APEX) | (r_state == S_FALL);
    assign hit       = r_hit;
    assign lives     = r_lives;
    assign game_over = (r_state == S_DEAD);

endmodule

// File: tb/tb_player_motion.sv
// Bench for player_motion: directed vector table, hand-written corner sequences, then random play
// checked every tick against a jump-timeline reference model.
module tb_player_motion;
    localparam int YG = 440, APEX = 320, RS = 2, FS = 2, AH = 20, JH = 120;
    localparam int XMIN = 50, XMAX = 590, SZ = 50, INV = 200;
    localparam int R = (JH + RS - 1) / RS;
    localparam int F = (JH + FS - 1) / FS;
    localparam int D = R + 1 + AH + F;     // jump length in ticks, from the takeoff edge to landing

    logic        clk_1s = 1'b0;
    logic        reset, jump_btn, left_btn, right_btn;
    logic [15:0] x_enemy, y_enemy;
    logic [15:0] x_player, y_player;
    logic        jumping, hit, game_over;
    logic [1:0]  lives;

    player_motion dut (
        .clk_1s(clk_1s), .reset(reset), .jump_btn(jump_btn), .left_btn(left_btn),
        .right_btn(right_btn), .x_enemy(x_enemy), .y_enemy(y_enemy),
        .x_player(x_player), .y_player(y_player), .jumping(jumping), .hit(hit),
        .lives(lives), .game_over(game_over)
    );

    always #5 clk_1s = ~clk_1s;

    int n_cmp = 0, n_fail = 0;

    // reference model: jump position derived from ticks elapsed since takeoff
    int m_x, m_y, m_jt, m_lives, m_inv;
    bit m_dead, m_hit, m_prev;

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int y_of(int jt);
        int y;
        if (jt == 0)               y = YG;
        else if (jt <= R + 1)      y = (YG - RS * (jt - 1) > APEX) ? YG - RS * (jt - 1) : APEX;
        else if (jt <= R + 1 + AH) y = APEX;
        else                       y = (APEX + FS * (jt - (R + 1 + AH)) < YG) ? APEX + FS * (jt - (R + 1 + AH)) : YG;
        return y;
    endfunction

    task automatic model_step(bit rst, bit jb, bit l, bit r, int ex, int ey);
        bit edge_s, hn;
        if (rst) begin
            m_x = 100; m_y = YG; m_jt = 0; m_lives = 3; m_inv = 0;
            m_dead = 0; m_hit = 0; m_prev = 0;
            return;
        end
        edge_s = jb && !m_prev;
        m_prev = jb;
        if (m_dead) begin m_hit = 0; return; end
        hn = (iabs(m_x - ex) < SZ) && (iabs(m_y - ey) < SZ) && (m_inv == 0);
        if (l && !r && m_x > XMIN)      m_x = m_x - 1;
        else if (r && !l && m_x < XMAX) m_x = m_x + 1;
        if (m_jt == 0) begin
            if (edge_s) m_jt = 1;
        end else begin
            m_jt = m_jt + 1;
            if (m_jt == D) m_jt = 0;
        end
        m_y = y_of(m_jt);
        m_hit = hn;
        if (hn) begin
            m_lives = m_lives - 1;
            m_inv = INV;
            if (m_lives == 0) m_dead = 1;
        end else if (m_inv > 0) begin
            m_inv = m_inv - 1;
        end
    endtask

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(bit rst, bit jb, bit l, bit r, int ex, int ey);
        reset = rst; jump_btn = jb; left_btn = l; right_btn = r;
        x_enemy = 16'(ex); y_enemy = 16'(ey);
        model_step(rst, jb, l, r, ex, ey);
        @(posedge clk_1s); #1;
        chk("x_player", int'(x_player), m_x);
        chk("y_player", int'(y_player), m_y);
        chk("lives", int'(lives), m_lives);
        chk("hit", int'(hit), int'(m_hit));
        chk("jumping", int'(jumping), int'(!m_dead && m_jt != 0));
        chk("game_over", int'(game_over), int'(m_dead));
    endtask

    typedef struct {
        int n; bit rst, jb, l, r; int ex, ey;
        int x, y, lv; bit hit, jmp, go;
    } row_t;

    row_t tbl[$];

    initial begin
        int ex, ey;
        bit jb;
        localparam int FAR = 1000;
        reset = 1; jump_btn = 0; left_btn = 0; right_btn = 0; x_enemy = 16'd1000; y_enemy = 16'd1000;

        //           n   rst jb l  r  ex   ey    x    y   lv hit jmp go
        tbl.push_back('{1,   1, 0, 0, 0, FAR, FAR, 100, 440, 3, 0, 0, 0});
        tbl.push_back('{10,  0, 0, 0, 0, FAR, FAR, 100, 440, 3, 0, 0, 0});
        tbl.push_back('{600, 0, 0, 0, 1, FAR, FAR, 590, 440, 3, 0, 0, 0});
        tbl.push_back('{600, 0, 0, 1, 0, FAR, FAR,  50, 440, 3, 0, 0, 0});
        tbl.push_back('{5,   0, 0, 1, 1, FAR, FAR,  50, 440, 3, 0, 0, 0});
        tbl.push_back('{50,  0, 0, 0, 1, FAR, FAR, 100, 440, 3, 0, 0, 0});
        tbl.push_back('{1,   0, 1, 0, 0, FAR, FAR, 100, 440, 3, 0, 1, 0});
        tbl.push_back('{10,  0, 0, 0, 0, FAR, FAR, 100, 420, 3, 0, 1, 0});
        tbl.push_back('{1,   0, 1, 0, 0, FAR, FAR, 100, 418, 3, 0, 1, 0});
        tbl.push_back('{49,  0, 0, 0, 0, FAR, FAR, 100, 320, 3, 0, 1, 0});
        tbl.push_back('{20,  0, 0, 0, 0, FAR, FAR, 100, 320, 3, 0, 1, 0});
        tbl.push_back('{1,   0, 0, 0, 0, FAR, FAR, 100, 322, 3, 0, 1, 0});
        tbl.push_back('{59,  0, 0, 0, 0, FAR, FAR, 100, 440, 3, 0, 0, 0});
        tbl.push_back('{1,   0, 0, 0, 0, 120, 400, 100, 440, 2, 1, 0, 0});
        tbl.push_back('{200, 0, 0, 0, 0, 120, 400, 100, 440, 2, 0, 0, 0});
        tbl.push_back('{1,   0, 0, 0, 0, 120, 400, 100, 440, 1, 1, 0, 0});
        tbl.push_back('{1,   0, 0, 0, 0, FAR, FAR, 100, 440, 1, 0, 0, 0});
        tbl.push_back('{200, 0, 0, 0, 0, FAR, FAR, 100, 440, 1, 0, 0, 0});
        tbl.push_back('{1,   0, 1, 0, 0, FAR, FAR, 100, 440, 1, 0, 1, 0});
        tbl.push_back('{60,  0, 0, 0, 0, FAR, FAR, 100, 320, 1, 0, 1, 0});
        tbl.push_back('{10,  0, 0, 0, 0, 100, 400, 100, 320, 1, 0, 1, 0});
        tbl.push_back('{80,  0, 0, 0, 0, FAR, FAR, 100, 440, 1, 0, 0, 0});
        tbl.push_back('{1,   0, 0, 0, 0, 100, 440, 100, 440, 0, 1, 0, 1});
        tbl.push_back('{20,  0, 1, 1, 0, 100, 440, 100, 440, 0, 0, 0, 1});
        tbl.push_back('{1,   1, 0, 0, 0, FAR, FAR, 100, 440, 3, 0, 0, 0});
        tbl.push_back('{1,   0, 1, 0, 0, FAR, FAR, 100, 440, 3, 0, 1, 0});
        tbl.push_back('{5,   0, 0, 0, 0, FAR, FAR, 100, 430, 3, 0, 1, 0});
        tbl.push_back('{1,   1, 0, 0, 0, FAR, FAR, 100, 440, 3, 0, 0, 0});

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++)
                apply(tbl[i].rst, tbl[i].jb, tbl[i].l, tbl[i].r, tbl[i].ex, tbl[i].ey);
            chk($sformatf("row%0d.x", i), int'(x_player), tbl[i].x);
            chk($sformatf("row%0d.y", i), int'(y_player), tbl[i].y);
            chk($sformatf("row%0d.lives", i), int'(lives), tbl[i].lv);
            chk($sformatf("row%0d.hit", i), int'(hit), int'(tbl[i].hit));
            chk($sformatf("row%0d.jumping", i), int'(jumping), int'(tbl[i].jmp));
            chk($sformatf("row%0d.game_over", i), int'(game_over), int'(tbl[i].go));
        end

        // hit and takeoff on the same edge both take effect
        apply(0, 1, 0, 0, 120, 400);
        chk("hit_and_jump.hit", int'(hit), 1);
        chk("hit_and_jump.jumping", int'(jumping), 1);
        chk("hit_and_jump.lives", int'(lives), 2);

        // hit on the landing edge leaves the landing intact
        apply(1, 0, 0, 0, FAR, FAR);
        apply(0, 1, 0, 0, FAR, FAR);
        for (int k = 0; k < D - 2; k++) apply(0, 0, 0, 0, FAR, FAR);
        chk("pre_land.y", int'(y_player), YG - FS);
        apply(0, 0, 0, 0, 100, 440);
        chk("land_hit.hit", int'(hit), 1);
        chk("land_hit.y", int'(y_player), YG);
        chk("land_hit.jumping", int'(jumping), 0);
        chk("land_hit.lives", int'(lives), 2);

        // random play around the player
        jb = 0;
        apply(1, 0, 0, 0, FAR, FAR);
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) jb = !jb;
            ex = m_x + int'($urandom_range(0, 140)) - 70;
            ey = m_y + int'($urandom_range(0, 140)) - 70;
            if (ex < 0) ex = 0;
            if (ey < 0) ey = 0;
            if ((m_dead && $urandom_range(0, 19) == 0) || $urandom_range(0, 499) == 0)
                apply(1, jb, 0, 0, ex, ey);
            else
                apply(0, jb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ex, ey);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
